// File: rtl/cve2_load_store_ctrl.sv
// Load/store unit bus controller: turns EX load/store requests into data-bus transactions.
// Define CVE2_LSU_MISALIGNED_EN to split misaligned accesses into two bus transactions;
// without it, a misaligned access is refused with an error response.
module cve2_load_store_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_valid_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        busy_o,
  output logic        load_err_o,
  output logic        store_err_o
);

  localparam logic [2:0] IDLE            = 3'd0;
  localparam logic [2:0] WAIT_GNT        = 3'd1;
  localparam logic [2:0] WAIT_RVALID     = 3'd2;
`ifdef CVE2_LSU_MISALIGNED_EN
  localparam logic [2:0] WAIT_GNT_MIS    = 3'd3;
  localparam logic [2:0] WAIT_RVALID_MIS = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  off;
  logic [3:0]  be_base;
  logic [7:0]  be_wide;
  logic        misaligned;
  logic        accept;
  logic [31:0] wdata_rot;

  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        sext_q;
  logic [1:0]  type_q;
  logic [1:0]  off_q;

  logic        resp_fire;
  logic        resp_err;
  logic [31:0] first;
  logic [31:0] load_word;

`ifdef CVE2_LSU_MISALIGNED_EN
  logic [3:0]  be2_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        split_q;
`else
  logic        mis_err_q;
`endif

  // Request decode from the EX-stage inputs
  assign off = adder_result_ex_i[1:0];

  always_comb begin
    case (lsu_type_i)
      2'b01:   be_base = 4'b0011;
      2'b10:   be_base = 4'b0001;
      default: be_base = 4'b1111;
    endcase
  end

  // Bits pushed above lane 3 form the second-part enables of a split access
  assign be_wide    = {4'b0000, be_base} << off;
  assign misaligned = |be_wide[7:4];

  always_comb begin
    case (off)
      2'd1:    wdata_rot = {lsu_wdata_i[23:0], lsu_wdata_i[31:24]};
      2'd2:    wdata_rot = {lsu_wdata_i[15:0], lsu_wdata_i[31:16]};
      2'd3:    wdata_rot = {lsu_wdata_i[7:0],  lsu_wdata_i[31:8]};
      default: wdata_rot = lsu_wdata_i;
    endcase
  end

`ifdef CVE2_LSU_MISALIGNED_EN
  assign accept = (state_q == IDLE) && lsu_req_i;
`else
  assign accept = (state_q == IDLE) && lsu_req_i && !mis_err_q;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef CVE2_LSU_MISALIGNED_EN
          if (misaligned) state_d = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
          else            state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
`else
          if (!misaligned) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
`endif
        end
      end
      WAIT_GNT: begin
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
`ifdef CVE2_LSU_MISALIGNED_EN
      WAIT_GNT_MIS: begin
        if (data_gnt_i) state_d = WAIT_RVALID_MIS;
      end
      WAIT_RVALID_MIS: begin
        if (data_rvalid_i) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
      end
`endif
      WAIT_RVALID: begin
        if (data_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs: combinational from EX in IDLE, held from registers while waiting
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = {word_q, 2'b00};
    data_we_o    = we_q;
    data_be_o    = be_q;
    data_wdata_o = wdata_q;
    case (state_q)
      IDLE: begin
`ifdef CVE2_LSU_MISALIGNED_EN
        data_req_o = accept;
`else
        data_req_o = accept && !misaligned;
`endif
        data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
        data_we_o    = lsu_we_i;
        data_be_o    = be_wide[3:0];
        data_wdata_o = wdata_rot;
      end
      WAIT_GNT: data_req_o = 1'b1;
`ifdef CVE2_LSU_MISALIGNED_EN
      WAIT_GNT_MIS: data_req_o = 1'b1;
      WAIT_RVALID_MIS: begin
        // Second part goes out in the same cycle the first part's data returns
        data_req_o  = data_rvalid_i;
        data_addr_o = {word_q + 30'd1, 2'b00};
        data_be_o   = be2_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      type_q  <= '0;
      off_q   <= '0;
`ifdef CVE2_LSU_MISALIGNED_EN
      be2_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
`else
      mis_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q  <= adder_result_ex_i[31:2];
        wdata_q <= wdata_rot;
        be_q    <= be_wide[3:0];
        we_q    <= lsu_we_i;
        sext_q  <= lsu_sign_ext_i;
        type_q  <= lsu_type_i;
        off_q   <= off;
`ifdef CVE2_LSU_MISALIGNED_EN
        be2_q   <= be_wide[7:4];
        err_q   <= 1'b0;
        split_q <= 1'b0;
`endif
      end
`ifdef CVE2_LSU_MISALIGNED_EN
      if ((state_q == WAIT_RVALID_MIS) && data_rvalid_i) begin
        rdata_q <= data_rdata_i;
        err_q   <= data_err_i;
        split_q <= 1'b1;
        word_q  <= word_q + 30'd1;
        be_q    <= be2_q;
      end
`else
      mis_err_q <= accept && misaligned;
`endif
    end
  end

  // Response path
  assign resp_fire = (state_q == WAIT_RVALID) && data_rvalid_i;

`ifdef CVE2_LSU_MISALIGNED_EN
  assign resp_err         = resp_fire && (data_err_i || err_q);
  assign lsu_resp_valid_o = resp_fire;
  assign first            = split_q ? rdata_q : data_rdata_i;
`else
  assign resp_err         = (resp_fire && data_err_i) || mis_err_q;
  assign lsu_resp_valid_o = resp_fire || mis_err_q;
  assign first            = data_rdata_i;
`endif

  assign lsu_resp_err_o    = resp_err;
  assign lsu_rdata_valid_o = lsu_resp_valid_o && !we_q && !resp_err;
  assign load_err_o        = resp_err && !we_q;
  assign store_err_o       = resp_err && we_q;
  assign busy_o            = (state_q != IDLE);

  // Low bytes come from the first word, spill-over bytes from the current beat
  always_comb begin
    case (off_q)
      2'd1:    load_word = {data_rdata_i[7:0],  first[31:8]};
      2'd2:    load_word = {data_rdata_i[15:0], first[31:16]};
      2'd3:    load_word = {data_rdata_i[23:0], first[31:24]};
      default: load_word = first;
    endcase
  end

  always_comb begin
    case (type_q)
      2'b01:   lsu_rdata_o = {{16{sext_q & load_word[15]}}, load_word[15:0]};
      2'b10:   lsu_rdata_o = {{24{sext_q & load_word[7]}}, load_word[7:0]};
      default: lsu_rdata_o = load_word;
    endcase
  end

endmodule

// File: tb/tb_cve2_load_store_ctrl.sv
// Scoreboard bench for cve2_load_store_ctrl; expected responses are queued as each
// access is driven and popped when the LSU reports a response.
module tb_cve2_load_store_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_wdata_i, adder_result_ex_i;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rdata_valid_o, lsu_resp_valid_o, lsu_resp_err_o;
  logic        busy_o, load_err_o, store_err_o;

  cve2_load_store_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .lsu_req_i         (lsu_req_i),
    .lsu_we_i          (lsu_we_i),
    .lsu_type_i        (lsu_type_i),
    .lsu_sign_ext_i    (lsu_sign_ext_i),
    .lsu_wdata_i       (lsu_wdata_i),
    .adder_result_ex_i (adder_result_ex_i),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_addr_o       (data_addr_o),
    .data_we_o         (data_we_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .data_rvalid_i     (data_rvalid_i),
    .data_err_i        (data_err_i),
    .data_rdata_i      (data_rdata_i),
    .lsu_rdata_o       (lsu_rdata_o),
    .lsu_rdata_valid_o (lsu_rdata_valid_o),
    .lsu_resp_valid_o  (lsu_resp_valid_o),
    .lsu_resp_err_o    (lsu_resp_err_o),
    .busy_o            (busy_o),
    .load_err_o        (load_err_o),
    .store_err_o       (store_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       mon_e;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk_i) begin
    if (lsu_resp_valid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", {31'b0, lsu_resp_valid_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err",   {31'b0, lsu_resp_err_o},    {31'b0, mon_e.err});
        check("rdata_valid",{31'b0, lsu_rdata_valid_o}, {31'b0, !mon_e.we && !mon_e.err});
        check("load_err",   {31'b0, load_err_o},        {31'b0, !mon_e.we && mon_e.err});
        check("store_err",  {31'b0, store_err_o},       {31'b0, mon_e.we && mon_e.err});
        if (!mon_e.we && !mon_e.err) check("rdata", lsu_rdata_o, mon_e.rdata);
      end
    end else if (load_err_o || store_err_o) begin
      check("err_without_resp", {30'b0, load_err_o, store_err_o}, 32'd0);
    end
  end

  // Entered and left one time unit after a rising edge.
  task automatic access(input logic we, input logic [1:0] ty, input logic sx,
                        input logic [31:0] wd, input logic [31:0] addr,
                        input int unsigned gdel, input int unsigned nparts,
                        input logic [31:0] exp_wd,
                        input logic [31:0] a0, input logic [3:0] be0,
                        input logic [31:0] rd0, input logic er0,
                        input logic [31:0] a1, input logic [3:0] be1,
                        input logic [31:0] rd1, input logic er1,
                        input logic [31:0] exp_rd);
    logic [31:0] pa;
    logic [3:0]  pbe;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = ty; lsu_sign_ext_i = sx;
    lsu_wdata_i = wd; adder_result_ex_i = addr;
    for (int p = 0; p < int'(nparts); p++) begin
      pa  = (p == 0) ? a0 : a1;
      pbe = (p == 0) ? be0 : be1;
      for (int k = 0; k <= int'(gdel); k++) begin
        if (k > 0) data_rvalid_i = 1'b0;
        data_gnt_i = (k == int'(gdel));
        #1;
        check("req",  {31'b0, data_req_o}, 32'd1);
        check("addr", data_addr_o, pa);
        check("be",   {28'b0, data_be_o}, {28'b0, pbe});
        check("we",   {31'b0, data_we_o}, {31'b0, we});
        if (we) check("wdata", data_wdata_o, exp_wd);
        @(posedge clk_i); #1;
        // Scramble EX inputs so held bus fields must come from registers
        lsu_req_i = 1'b0; data_gnt_i = 1'b0;
        adder_result_ex_i = ~addr; lsu_wdata_i = ~wd;
        lsu_type_i = ty ^ 2'b11; lsu_sign_ext_i = ~sx; lsu_we_i = ~we;
      end
      data_rvalid_i = 1'b1;
      data_rdata_i  = (p == 0) ? rd0 : rd1;
      data_err_i    = (p == 0) ? er0 : er1;
    end
    exp_q.push_back('{rdata: exp_rd, err: er0 | er1, we: we});
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
    check("resp_seen", exp_q.size(), 32'd0);
    check("idle_after", {31'b0, busy_o}, 32'd0);
  endtask

`ifndef CVE2_LSU_MISALIGNED_EN
  task automatic mis_access(input logic we, input logic [1:0] ty, input logic [31:0] addr);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = ty; lsu_sign_ext_i = 1'b0;
    adder_result_ex_i = addr; data_gnt_i = 1'b0;
    #1;
    check("mis_no_req", {31'b0, data_req_o}, 32'd0);
    @(negedge clk_i); #1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, we: we});
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    check("mis_no_req2", {31'b0, data_req_o}, 32'd0);
    @(posedge clk_i); #1;
    check("mis_resp_seen", exp_q.size(), 32'd0);
  endtask
`endif

  initial begin
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'd0; lsu_sign_ext_i = 1'b0;
    lsu_wdata_i = '0; adder_result_ex_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy",       {31'b0, busy_o}, 32'd0);
    check("rst_req",        {31'b0, data_req_o}, 32'd0);
    check("rst_resp_valid", {31'b0, lsu_resp_valid_o}, 32'd0);
    check("rst_rdata_valid",{31'b0, lsu_rdata_valid_o}, 32'd0);
    check("rst_resp_err",   {31'b0, lsu_resp_err_o}, 32'd0);
    check("rst_errs",       {30'b0, load_err_o, store_err_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    //     we ty sx wdata         addr          gd np exp_wd         a0            be0      rd0           e0  a1           be1      rd1           e1  exp_rd
    access(0, 0, 0, 32'h0,        32'h100,      0, 1, 32'h0,         32'h100,      4'b1111, 32'hDEADBEEF, 0,  32'h0,       4'b0000, 32'h0,        0,  32'hDEADBEEF);
    access(0, 2, 1, 32'h0,        32'h203,      1, 1, 32'h0,         32'h200,      4'b1000, 32'h80123456, 0,  32'h0,       4'b0000, 32'h0,        0,  32'hFFFFFF80);
    access(0, 2, 0, 32'h0,        32'h201,      0, 1, 32'h0,         32'h200,      4'b0010, 32'h0000AB00, 0,  32'h0,       4'b0000, 32'h0,        0,  32'h000000AB);
    access(0, 1, 1, 32'h0,        32'h302,      2, 1, 32'h0,         32'h300,      4'b1100, 32'h9ABC1234, 0,  32'h0,       4'b0000, 32'h0,        0,  32'hFFFF9ABC);
    access(0, 1, 0, 32'h0,        32'h302,      0, 1, 32'h0,         32'h300,      4'b1100, 32'h9ABC1234, 0,  32'h0,       4'b0000, 32'h0,        0,  32'h00009ABC);
    access(0, 1, 1, 32'h0,        32'h300,      0, 1, 32'h0,         32'h300,      4'b0011, 32'hFFFF7FFF, 0,  32'h0,       4'b0000, 32'h0,        0,  32'h00007FFF);
    access(1, 0, 0, 32'h11223344, 32'h400,      2, 1, 32'h11223344,  32'h400,      4'b1111, 32'h0,        0,  32'h0,       4'b0000, 32'h0,        0,  32'h0);
    access(1, 2, 0, 32'h000000A5, 32'h501,      0, 1, 32'h0000A500,  32'h500,      4'b0010, 32'h0,        0,  32'h0,       4'b0000, 32'h0,        0,  32'h0);
    access(1, 1, 0, 32'h0000BEEF, 32'h602,      1, 1, 32'hBEEF0000,  32'h600,      4'b1100, 32'h0,        0,  32'h0,       4'b0000, 32'h0,        0,  32'h0);
    access(0, 0, 0, 32'h0,        32'h700,      0, 1, 32'h0,         32'h700,      4'b1111, 32'h12345678, 1,  32'h0,       4'b0000, 32'h0,        0,  32'h0);
    access(1, 0, 0, 32'hCAFEF00D, 32'h704,      1, 1, 32'hCAFEF00D,  32'h704,      4'b1111, 32'h0,        1,  32'h0,       4'b0000, 32'h0,        0,  32'h0);
`ifdef CVE2_LSU_MISALIGNED_EN
    access(0, 1, 1, 32'h0,        32'h103,      0, 2, 32'h0,         32'h100,      4'b1000, 32'h80000000, 0,  32'h104,     4'b0001, 32'h000000FF, 0,  32'hFFFFFF80);
    access(0, 1, 0, 32'h0,        32'h103,      1, 2, 32'h0,         32'h100,      4'b1000, 32'h80000000, 0,  32'h104,     4'b0001, 32'h000000FF, 0,  32'h0000FF80);
    access(1, 0, 0, 32'h11223344, 32'h101,      3, 2, 32'h22334411,  32'h100,      4'b1110, 32'h0,        0,  32'h104,     4'b0001, 32'h0,        0,  32'h0);
    access(0, 0, 0, 32'h0,        32'h202,      0, 2, 32'h0,         32'h200,      4'b1100, 32'h12340000, 1,  32'h204,     4'b0011, 32'h00005678, 0,  32'h0);
    access(0, 0, 0, 32'h0,        32'hFFFFFFFE, 1, 2, 32'h0,         32'hFFFFFFFC, 4'b1100, 32'h55660000, 0,  32'h00000000,4'b0011, 32'h00007788, 0,  32'h77885566);
`else
    mis_access(1'b0, 2'd0, 32'h001);
    mis_access(1'b1, 2'd1, 32'h003);
`endif

    // Reset while waiting for rvalid, then a stray rvalid after release
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'd0; adder_result_ex_i = 32'h800;
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0; data_gnt_i = 1'b0;
    check("busy_wait_rvalid", {31'b0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("busy_in_reset", {31'b0, busy_o}, 32'd0);
    check("req_in_reset",  {31'b0, data_req_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h0BADF00D;
    #1;
    check("stray_resp_valid", {31'b0, lsu_resp_valid_o}, 32'd0);
    check("stray_busy",       {31'b0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    check("stray_idle", {31'b0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
